// File: rtl/arbitro_bus_rtc.sv
// Purpose : arbitrates init/write/read requests onto a multiplexed RTC bus (A_D, CS_n, RD_n, WR_n, ad_out/ad_in).
// Latency : 2 cycles request->DIR_ACT, 4*T_FASE cycles per transaction, 1-cycle FIN done pulse, back in IDLE 1 cycle later.
// Backpr. : level requests are held by the requester until its done pulse; requests are ignored while busy.
//
// Ports:
//   clk, reset_n                  clock and asynchronous active-low reset
//   req_ini/req_esc/req_lee       level requests: init sequence, user write, read
//   dir_esc, dato_esc, dir_lee    write address/data and read address, sampled at grant
//   done_ini/done_esc/done_lee    one-cycle completion pulses
//   dato_leido                    last byte read, held until the next read completes
//   ocupado                       high whenever the arbiter is not IDLE
//   A_D, CS_n, RD_n, WR_n         bus controls (A_D: 0 = address phase)
//   ad_out, en_out, ad_in         multiplexed bus output, its tri-state enable, and readback
module arbitro_bus_rtc #(
  parameter int unsigned T_FASE = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_ini,
  input  logic       req_esc,
  input  logic       req_lee,
  input  logic [7:0] dir_esc,
  input  logic [7:0] dato_esc,
  input  logic [7:0] dir_lee,
  output logic       done_ini,
  output logic       done_esc,
  output logic       done_lee,
  output logic [7:0] dato_leido,
  output logic       ocupado,
  output logic       A_D,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic [7:0] ad_out,
  output logic       en_out,
  input  logic [7:0] ad_in
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARB     = 3'd1;
  localparam logic [2:0] S_DIR_ACT = 3'd2;
  localparam logic [2:0] S_DIR_REC = 3'd3;
  localparam logic [2:0] S_DAT_ACT = 3'd4;
  localparam logic [2:0] S_DAT_REC = 3'd5;
  localparam logic [2:0] S_FIN     = 3'd6;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_INI  = 2'd1;
  localparam logic [1:0] G_ESC  = 2'd2;
  localparam logic [1:0] G_LEE  = 2'd3;

  localparam logic [7:0] CNT_RELOAD = 8'(T_FASE - 1);

  // Init sequence table: {address, data} for each of the three writes.
  function automatic logic [15:0] init_word(input logic [1:0] idx);
    logic [15:0] w;
    case (idx)
      2'd0:    w = {8'h02, 8'h10};
      2'd1:    w = {8'h02, 8'h00};
      default: w = {8'h10, 8'hD2};
    endcase
    return w;
  endfunction

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] dir_q, dir_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] dato_leido_q, dato_leido_d;

  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       a_d_q, a_d_d;
  logic       en_out_q, en_out_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       ocupado_q, ocupado_d;
  logic       done_ini_q, done_ini_d;
  logic       done_esc_q, done_esc_d;
  logic       done_lee_q, done_lee_d;

  logic [15:0] next_init;
  assign next_init = init_word(idx_q + 2'd1);

  // Next-state logic. Each timed phase reloads the counter on entry and
  // advances when the counter has run down to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    dat_d   = dat_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (req_ini || req_esc || req_lee) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        cnt_d = CNT_RELOAD;
        idx_d = 2'd0;
        if (req_ini) begin
          grant_d = G_INI;
          {dir_d, dat_d} = init_word(2'd0);
          state_d = S_DIR_ACT;
        end else if (req_esc) begin
          grant_d = G_ESC;
          dir_d   = dir_esc;
          dat_d   = dato_esc;
          state_d = S_DIR_ACT;
        end else if (req_lee) begin
          grant_d = G_LEE;
          dir_d   = dir_lee;
          dat_d   = 8'h00;
          state_d = S_DIR_ACT;
        end else begin
          // Request vanished between IDLE and ARB: nothing to serve.
          grant_d = G_NONE;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end
      end
      S_DIR_ACT, S_DIR_REC, S_DAT_ACT: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = CNT_RELOAD;
          state_d = state_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DAT_REC: begin
        if (cnt_q == 8'd0) begin
          if (grant_q == G_INI && idx_q != 2'd2) begin
            // Chain the next init write without passing through IDLE.
            idx_d          = idx_q + 2'd1;
            {dir_d, dat_d} = next_init;
            cnt_d          = CNT_RELOAD;
            state_d        = S_DIR_ACT;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_FIN;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_FIN: begin
        cnt_d   = 8'd0;
        grant_d = G_NONE;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 8'd0;
        grant_d = G_NONE;
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they change in the
  // same cycle the state register does, without combinational glitches.
  always_comb begin
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    a_d_d    = 1'b0;
    en_out_d = 1'b0;
    ad_out_d = 8'h00;
    case (state_d)
      S_DIR_ACT: begin
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        en_out_d = 1'b1;
        ad_out_d = dir_d;
      end
      S_DIR_REC: begin
        en_out_d = 1'b1;
        ad_out_d = dir_d;
      end
      S_DAT_ACT: begin
        cs_n_d = 1'b0;
        a_d_d  = 1'b1;
        if (grant_d == G_LEE) begin
          // Bus released so the RTC can drive ad_in.
          rd_n_d = 1'b0;
        end else begin
          wr_n_d   = 1'b0;
          en_out_d = 1'b1;
          ad_out_d = dat_d;
        end
      end
      S_DAT_REC: begin
        a_d_d = 1'b1;
      end
      default: ;
    endcase
    ocupado_d  = (state_d != S_IDLE);
    done_ini_d = (state_d == S_FIN) && (grant_d == G_INI);
    done_esc_d = (state_d == S_FIN) && (grant_d == G_ESC);
    done_lee_d = (state_d == S_FIN) && (grant_d == G_LEE);
  end

  // Capture the read byte on the last cycle of the read strobe.
  always_comb begin
    dato_leido_d = dato_leido_q;
    if (state_q == S_DAT_ACT && cnt_q == 8'd0 && grant_q == G_LEE) begin
      dato_leido_d = ad_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      grant_q      <= G_NONE;
      idx_q        <= 2'd0;
      dir_q        <= 8'h00;
      dat_q        <= 8'h00;
      dato_leido_q <= 8'h00;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      a_d_q        <= 1'b0;
      en_out_q     <= 1'b0;
      ad_out_q     <= 8'h00;
      ocupado_q    <= 1'b0;
      done_ini_q   <= 1'b0;
      done_esc_q   <= 1'b0;
      done_lee_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      idx_q        <= idx_d;
      dir_q        <= dir_d;
      dat_q        <= dat_d;
      dato_leido_q <= dato_leido_d;
      cs_n_q       <= cs_n_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      a_d_q        <= a_d_d;
      en_out_q     <= en_out_d;
      ad_out_q     <= ad_out_d;
      ocupado_q    <= ocupado_d;
      done_ini_q   <= done_ini_d;
      done_esc_q   <= done_esc_d;
      done_lee_q   <= done_lee_d;
    end
  end

  assign CS_n       = cs_n_q;
  assign RD_n       = rd_n_q;
  assign WR_n       = wr_n_q;
  assign A_D        = a_d_q;
  assign en_out     = en_out_q;
  assign ad_out     = ad_out_q;
  assign ocupado    = ocupado_q;
  assign done_ini   = done_ini_q;
  assign done_esc   = done_esc_q;
  assign done_lee   = done_lee_q;
  assign dato_leido = dato_leido_q;

endmodule

// File: tb/tb_arbitro_bus_rtc.sv
// Purpose : scoreboard bench for arbitro_bus_rtc (T_FASE=10 main instance, T_FASE=2 timing instance).
// Latency : expected bus transactions and done pulses are queued at stimulus time and popped by monitors.
// Backpr. : requests are held until the matching done pulse, then dropped.
module tb_arbitro_bus_rtc;

  localparam int T = 10;

  typedef struct {
    bit         is_done;
    int         who;      // 0 ini, 1 esc, 2 lee
    bit         rd;
    logic [7:0] addr;
    logic [7:0] data;     // write data, or expected dato_leido for a read done
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       req_ini, req_esc, req_lee;
  logic [7:0] dir_esc, dato_esc, dir_lee, ad_in;
  logic       done_ini, done_esc, done_lee;
  logic [7:0] dato_leido, ad_out;
  logic       ocupado, A_D, CS_n, RD_n, WR_n, en_out;

  logic       req_ini2, req_esc2, req_lee2;
  logic [7:0] dir_esc2, dato_esc2, dir_lee2, ad_in2;
  logic       done_ini2, done_esc2, done_lee2;
  logic [7:0] dato_leido2, ad_out2;
  logic       ocupado2, A_D2, CS_n2, RD_n2, WR_n2, en_out2;

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  int   q2[$];

  arbitro_bus_rtc #(.T_FASE(T)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_ini(req_ini), .req_esc(req_esc), .req_lee(req_lee),
    .dir_esc(dir_esc), .dato_esc(dato_esc), .dir_lee(dir_lee),
    .done_ini(done_ini), .done_esc(done_esc), .done_lee(done_lee),
    .dato_leido(dato_leido), .ocupado(ocupado),
    .A_D(A_D), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
    .ad_out(ad_out), .en_out(en_out), .ad_in(ad_in)
  );

  arbitro_bus_rtc #(.T_FASE(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .req_ini(req_ini2), .req_esc(req_esc2), .req_lee(req_lee2),
    .dir_esc(dir_esc2), .dato_esc(dato_esc2), .dir_lee(dir_lee2),
    .done_ini(done_ini2), .done_esc(done_esc2), .done_lee(done_lee2),
    .dato_leido(dato_leido2), .ocupado(ocupado2),
    .A_D(A_D2), .CS_n(CS_n2), .RD_n(RD_n2), .WR_n(WR_n2),
    .ad_out(ad_out2), .en_out(en_out2), .ad_in(ad_in2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_txn(input bit rd, input logic [7:0] addr, input logic [7:0] data);
    exp_t e;
    e.is_done = 1'b0; e.who = 0; e.rd = rd; e.addr = addr; e.data = data;
    expq.push_back(e);
  endtask

  task automatic push_done(input int who, input logic [7:0] data);
    exp_t e;
    e.is_done = 1'b1; e.who = who; e.rd = 1'b0; e.addr = 8'h00; e.data = data;
    expq.push_back(e);
  endtask

  // what: 0 done_ini, 1 done_esc, 2 done_lee, 3 done_esc2, 4 done_lee2, 5 CS_n low, 6 data phase
  task automatic wait_for(input int what, input int budget, input string name);
    int  n;
    bit  hit;
    n = 0;
    forever begin
      @(negedge clk);
      case (what)
        0: hit = done_ini;
        1: hit = done_esc;
        2: hit = done_lee;
        3: hit = done_esc2;
        4: hit = done_lee2;
        5: hit = !CS_n;
        default: hit = !CS_n && A_D;
      endcase
      if (hit) break;
      n++;
      if (n > budget) begin
        checks++;
        errors++;
        $display("FAIL timeout_%s waited=%0d cycles required_event_within=%0d", name, n, budget);
        break;
      end
    end
  endtask

  // Main-instance monitor: rebuilds each bus transaction and each done pulse
  // and compares against the head of the expectation queue.
  initial begin : mon
    int         cyc, ph, alen, rlen, dlen, start, who;
    bit         ok, rd;
    logic [7:0] addr, data;
    exp_t       e;
    cyc = 0; ph = 0; alen = 0; rlen = 0; dlen = 0; start = 0; ok = 1'b1; rd = 1'b0;
    addr = 8'h00; data = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        ph = 0;
        continue;
      end
      chk("inv_rd_wr_low", 32'(!RD_n && !WR_n), 32'd0);
      chk("inv_en_while_rd", 32'(en_out && !RD_n), 32'd0);

      if (done_ini || done_esc || done_lee) begin
        who = done_ini ? 0 : (done_esc ? 1 : 2);
        chk("done_onehot", 32'(done_ini) + 32'(done_esc) + 32'(done_lee), 32'd1);
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected who=%0d required=none", who);
        end else begin
          e = expq.pop_front();
          chk("done_is_done", 32'(e.is_done), 32'd1);
          chk("done_who", 32'(who), 32'(e.who));
          chk("done_latency", 32'(cyc - start), 32'(4 * T));
          if (e.who == 2) chk("dato_leido", 32'(dato_leido), 32'(e.data));
        end
      end

      case (ph)
        0: begin
          if (!CS_n && !A_D) begin
            ph = 1; start = cyc; addr = ad_out; alen = 1;
            ok = en_out && !WR_n && RD_n;
          end
        end
        1: begin
          if (!CS_n) begin
            alen++;
            ok = ok && !A_D && en_out && !WR_n && RD_n && (ad_out == addr);
          end else begin
            ph = 2; rlen = 1;
            ok = ok && en_out && WR_n && RD_n && (ad_out == addr);
          end
        end
        2: begin
          if (CS_n) begin
            rlen++;
            ok = ok && en_out && WR_n && RD_n && (ad_out == addr);
          end else begin
            ph = 3; dlen = 1; rd = !RD_n; data = ad_out;
            ok = ok && A_D && (rd ? (!en_out && WR_n) : (en_out && !WR_n && RD_n));
          end
        end
        default: begin
          if (!CS_n) begin
            dlen++;
            ok = ok && A_D && (rd == !RD_n) &&
                 (rd ? (!en_out && WR_n) : (en_out && !WR_n && RD_n && (ad_out == data)));
          end else begin
            ph = 0;
            ok = ok && !en_out && WR_n && RD_n;
            if (expq.size() == 0) begin
              checks++; errors++;
              $display("FAIL txn_unexpected addr=%0h required=none", addr);
            end else begin
              e = expq.pop_front();
              chk("txn_is_txn", 32'(e.is_done), 32'd0);
              chk("txn_rd", 32'(rd), 32'(e.rd));
              chk("txn_addr", 32'(addr), 32'(e.addr));
              if (!e.rd) chk("txn_data", 32'(data), 32'(e.data));
              chk("txn_addr_len", 32'(alen), 32'(T));
              chk("txn_rec_len", 32'(rlen), 32'(T));
              chk("txn_data_len", 32'(dlen), 32'(T));
              chk("txn_strobes", 32'(ok), 32'd1);
            end
          end
        end
      endcase
    end
  end

  // T_FASE=2 monitor: invariants every cycle, request-to-done timing per transaction.
  initial begin : mon2
    int cyc2, start2;
    bit in_txn;
    cyc2 = 0; start2 = 0; in_txn = 1'b0;
    forever begin
      @(negedge clk);
      cyc2++;
      if (!reset_n) begin
        in_txn = 1'b0;
        continue;
      end
      chk("t2_inv_rd_wr_low", 32'(!RD_n2 && !WR_n2), 32'd0);
      chk("t2_inv_en_while_rd", 32'(en_out2 && !RD_n2), 32'd0);
      if (!CS_n2 && !A_D2 && !in_txn) begin
        in_txn = 1'b1;
        start2 = cyc2;
      end
      if (done_ini2 || done_esc2 || done_lee2) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL t2_done_unexpected required=none");
        end else begin
          chk("t2_latency", 32'(cyc2 - start2), 32'(q2.pop_front()));
        end
        in_txn = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    reset_n = 1'b0;
    req_ini = 1'b0; req_esc = 1'b0; req_lee = 1'b0;
    dir_esc = 8'h00; dato_esc = 8'h00; dir_lee = 8'h00; ad_in = 8'h00;
    req_ini2 = 1'b0; req_esc2 = 1'b0; req_lee2 = 1'b0;
    dir_esc2 = 8'h00; dato_esc2 = 8'h00; dir_lee2 = 8'h00; ad_in2 = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_CS_n", 32'(CS_n), 32'd1);
    chk("rst_RD_n", 32'(RD_n), 32'd1);
    chk("rst_WR_n", 32'(WR_n), 32'd1);
    chk("rst_A_D", 32'(A_D), 32'd0);
    chk("rst_en_out", 32'(en_out), 32'd0);
    chk("rst_ad_out", 32'(ad_out), 32'h00);
    chk("rst_dato_leido", 32'(dato_leido), 32'h00);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_done", {29'd0, done_ini, done_esc, done_lee}, 32'd0);

    // Write 0x45 to 0x21, request already pending at reset release.
    dir_esc = 8'h21; dato_esc = 8'h45; req_esc = 1'b1;
    push_txn(1'b0, 8'h21, 8'h45);
    push_done(1, 8'h00);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("no_grant_edge1_CS_n", 32'(CS_n), 32'd1);
    chk("arb_edge1_ocupado", 32'(ocupado), 32'd1);
    @(posedge clk); #1;
    chk("grant_edge2_CS_n", 32'(CS_n), 32'd0);
    chk("grant_edge2_ad_out", 32'(ad_out), 32'h21);
    wait_for(1, 100, "done_esc_write");
    req_esc = 1'b0;
    repeat (3) @(negedge clk);

    // Read from 0x22, RTC returns 0x37.
    dir_lee = 8'h22; ad_in = 8'h37; req_lee = 1'b1;
    push_txn(1'b1, 8'h22, 8'h00);
    push_done(2, 8'h37);
    wait_for(2, 100, "done_lee_read");
    req_lee = 1'b0;
    repeat (3) @(negedge clk);
    chk("read_dato_leido_held", 32'(dato_leido), 32'h37);

    // All three requests rise together: init sequence, then write, then read.
    dir_esc = 8'h30; dato_esc = 8'h5A; dir_lee = 8'h44; ad_in = 8'hA5;
    push_txn(1'b0, 8'h02, 8'h10);
    push_txn(1'b0, 8'h02, 8'h00);
    push_txn(1'b0, 8'h10, 8'hD2);
    push_done(0, 8'h00);
    push_txn(1'b0, 8'h30, 8'h5A);
    push_done(1, 8'h00);
    push_txn(1'b1, 8'h44, 8'h00);
    push_done(2, 8'hA5);
    req_ini = 1'b1; req_esc = 1'b1; req_lee = 1'b1;
    n = 0;
    while ((req_ini || req_esc || req_lee) && n < 600) begin
      @(negedge clk);
      n++;
      if (done_ini) req_ini = 1'b0;
      if (done_esc) req_esc = 1'b0;
      if (done_lee) req_lee = 1'b0;
    end
    if (req_ini || req_esc || req_lee) begin
      checks++; errors++;
      $display("FAIL timeout_triple pending=%b required=000", {req_ini, req_esc, req_lee});
      req_ini = 1'b0; req_esc = 1'b0; req_lee = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Read request dropped during the address phase still completes.
    dir_lee = 8'h4B; ad_in = 8'h5C; req_lee = 1'b1;
    push_txn(1'b1, 8'h4B, 8'h00);
    push_done(2, 8'h5C);
    wait_for(5, 20, "cs_low_drop");
    repeat (3) @(negedge clk);
    req_lee = 1'b0;
    wait_for(2, 100, "done_lee_dropped");
    repeat (3) @(negedge clk);

    // Reset during the data phase of a write: no done, bus idle at once.
    dir_esc = 8'h33; dato_esc = 8'h66; req_esc = 1'b1;
    wait_for(6, 60, "data_phase_reset");
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    req_esc = 1'b0;
    #1;
    chk("async_rst_CS_n", 32'(CS_n), 32'd1);
    chk("async_rst_WR_n", 32'(WR_n), 32'd1);
    chk("async_rst_RD_n", 32'(RD_n), 32'd1);
    chk("async_rst_en_out", 32'(en_out), 32'd0);
    chk("async_rst_ad_out", 32'(ad_out), 32'h00);
    chk("async_rst_ocupado", 32'(ocupado), 32'd0);
    chk("async_rst_dato_leido", 32'(dato_leido), 32'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_idle_ocupado", 32'(ocupado), 32'd0);
    chk("post_rst_idle_CS_n", 32'(CS_n), 32'd1);

    // T_FASE=2 instance: 8-cycle write and read with invariants watched.
    dir_esc2 = 8'h12; dato_esc2 = 8'h34; req_esc2 = 1'b1;
    q2.push_back(8);
    wait_for(3, 40, "t2_done_esc");
    req_esc2 = 1'b0;
    repeat (3) @(negedge clk);
    dir_lee2 = 8'h56; ad_in2 = 8'h99; req_lee2 = 1'b1;
    q2.push_back(8);
    wait_for(4, 40, "t2_done_lee");
    req_lee2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_dato_leido", 32'(dato_leido2), 32'h99);

    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    chk("t2_scoreboard_drained", 32'(q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
